uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_if.sv | 32 +++
 rtl/baud_tick_detect.sv | 27 ++
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and its benches.
//   state_e        transmitter FSM state encoding
//   BAUD_DIV_OPT*  baud decoder divisors; one bit period lasts divisor+1
//                  sys_clk cycles at 50 MHz
//   frame_parity   parity bit for a byte (odd = 1 selects odd parity)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam int unsigned BAUD_DIV_OPT0 = 5207;
  localparam int unsigned BAUD_DIV_OPT1 = 2603;
  localparam int unsigned BAUD_DIV_OPT2 = 867;
  localparam int unsigned BAUD_DIV_OPT3 = 217;

  // XOR of the data bits gives even parity; XOR in the odd flag flips it.
  function automatic logic frame_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: request/status bundle between a byte source and uart_tx.
//   tx_data     byte to send, LSB first
//   tx_start    single-cycle request to send tx_data
//   parity_en   1 = append a parity bit after the data bits
//   parity_odd  1 = odd parity, 0 = even (ignored when parity_en = 0)
//   tx_busy     frame in flight
//   tx_done     one-cycle pulse when the last stop bit completes
//
// Handshake: a request is the cycle in which tx_start = 1. It is accepted
// exactly when tx_busy = 0 in that cycle (tx_busy is the ready signal,
// inverted); tx_data/parity_en/parity_odd are captured in that cycle only.
// A request while tx_busy = 1 is dropped, never queued. tx_busy rises the
// cycle after acceptance and falls in the same cycle tx_done pulses, so a
// new request may be issued in the tx_done cycle.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       parity_en;
  logic       parity_odd;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_data, tx_start, parity_en, parity_odd,
    input  tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_start, parity_en, parity_odd,
    output tx_busy, tx_done
  );
endinterface

// File: rtl/baud_tick_detect.sv
// baud_tick_detect: turns each toggle of baud_clk into a one-cycle tick.
//   sys_clk   system clock
//   reset_n   asynchronous active-low reset
//   baud_clk  divided clock from the baud decoder (already in sys_clk domain)
//   tick      high for one cycle after either edge of baud_clk
// baud_clk comes from a register clocked by sys_clk, so it is used directly
// without a synchroniser.
module baud_tick_detect (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic baud_clk,
  output logic tick
);

  logic baud_clk_d;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_clk_d <= 1'b0;
    end else begin
      baud_clk_d <= baud_clk;
    end
  end

  assign tick = baud_clk ^ baud_clk_d;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, LSB first, optional parity, 1 or 2 stops.
//   STOP_BITS  stop bits per frame (1 or 2)
//   sys_clk    system clock, all state on its rising edge
//   reset_n    asynchronous active-low reset; aborts any frame, tx goes high
//   baud_clk   divided clock from the baud decoder; each toggle = one bit
//   baud_en    enable to the baud decoder, high while a frame is in flight
//   tx         serial line, idle high
//   bus        request/status bundle (slave side), see uart_tx_if
//   dbg_state  current FSM state
// All outputs are registered: the next values are computed from the next
// state so tx changes on the same edge as the state.
module uart_tx
  import uart_pkg::*;
#(
  parameter int STOP_BITS = 1
) (
  input  logic      sys_clk,
  input  logic      reset_n,
  input  logic      baud_clk,
  output logic      baud_en,
  output logic      tx,
  uart_tx_if.slave  bus,
  output state_e    dbg_state
);

  // Value of the stop counter on the tick that ends the frame.
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  logic       tick;
  state_e     state, state_n;
  logic [2:0] bit_idx, idx_n;
  logic       stop_cnt, stop_n;
  logic [7:0] data_q, data_n;
  logic       pen_q, pen_n;
  logic       par_q, par_n;
  logic       tx_q, tx_n;
  logic       en_q, en_n;
  logic       busy_q, busy_n;
  logic       done_q, done_n;

  baud_tick_detect u_tick (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .baud_clk (baud_clk),
    .tick     (tick)
  );

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      bit_idx  <= 3'd0;
      stop_cnt <= 1'b0;
      data_q   <= 8'd0;
      pen_q    <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      bit_idx  <= idx_n;
      stop_cnt <= stop_n;
      data_q   <= data_n;
      pen_q    <= pen_n;
      par_q    <= par_n;
      tx_q     <= tx_n;
      en_q     <= en_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = bit_idx;
    stop_n  = stop_cnt;
    data_n  = data_q;
    pen_n   = pen_q;
    par_n   = par_q;
    done_n  = 1'b0;

    case (state)
      // Ticks are ignored here; only a request moves the FSM, and the
      // options are captured so later input activity cannot alter the frame.
      ST_IDLE: begin
        if (bus.tx_start) begin
          data_n  = bus.tx_data;
          pen_n   = bus.parity_en;
          par_n   = frame_parity(bus.tx_data, bus.parity_odd);
          idx_n   = 3'd0;
          stop_n  = 1'b0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          idx_n   = 3'd0;
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            stop_n  = 1'b0;
            state_n = pen_q ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          stop_n  = 1'b0;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt == STOP_LAST) begin
            stop_n  = 1'b0;
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            stop_n = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = data_n[idx_n];
      ST_PARITY: tx_n = par_n;
      default:   tx_n = 1'b1;
    endcase

    en_n   = (state_n != ST_IDLE);
    busy_n = (state_n != ST_IDLE);
  end

  assign tx          = tx_q;
  assign baud_en     = en_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: bench for uart_tx. Two instances run side by side, one with
// one stop bit and one with two. A behavioural baud decoder (option 2'b11,
// 218 cycles per bit) feeds each. Expected line levels come from a frame
// model that lists the bits of a frame from the UART framing rules.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int BIT_CYC = BAUD_DIV_OPT3 + 1;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // ---------------- stimulus / observation signals ----------------
  logic [7:0] data_v;
  logic       pen_v;
  logic       podd_v;
  logic [1:0] start_v;
  logic [1:0] baud_clk_v;
  wire  [1:0] en_w;
  wire  [1:0] tx_w;
  wire  [1:0] busy_w;
  wire  [1:0] done_w;
  state_e     dbg0, dbg1;

  uart_tx_if bus0 ();
  uart_tx_if bus1 ();

  assign bus0.tx_data    = data_v;
  assign bus0.parity_en  = pen_v;
  assign bus0.parity_odd = podd_v;
  assign bus0.tx_start   = start_v[0];
  assign bus1.tx_data    = data_v;
  assign bus1.parity_en  = pen_v;
  assign bus1.parity_odd = podd_v;
  assign bus1.tx_start   = start_v[1];
  assign busy_w[0] = bus0.tx_busy;
  assign busy_w[1] = bus1.tx_busy;
  assign done_w[0] = bus0.tx_done;
  assign done_w[1] = bus1.tx_done;

  uart_tx #(.STOP_BITS(1)) dut0 (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .baud_clk  (baud_clk_v[0]),
    .baud_en   (en_w[0]),
    .tx        (tx_w[0]),
    .bus       (bus0),
    .dbg_state (dbg0)
  );

  uart_tx #(.STOP_BITS(2)) dut1 (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .baud_clk  (baud_clk_v[1]),
    .baud_en   (en_w[1]),
    .tx        (tx_w[1]),
    .bus       (bus1),
    .dbg_state (dbg1)
  );

  // Baud decoder model: toggles baud_clk every BIT_CYC enabled cycles.
  // The counter idles at 1 because the transmitter drops tx one cycle
  // before baud_en reaches the decoder; this keeps the start bit the same
  // length as every other bit.
  logic [12:0] bcnt [2];
  always @(posedge sys_clk or negedge reset_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        bcnt[d]       <= 13'd1;
        baud_clk_v[d] <= 1'b0;
      end else if (!en_w[d]) begin
        bcnt[d] <= 13'd1;
      end else if (bcnt[d] == 13'(BAUD_DIV_OPT3)) begin
        bcnt[d]       <= 13'd0;
        baud_clk_v[d] <= ~baud_clk_v[d];
      end else begin
        bcnt[d] <= bcnt[d] + 13'd1;
      end
    end
  end

  // tx_done pulse counters.
  int done_cnt [2] = '{0, 0};
  always @(posedge sys_clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done_w[d] === 1'b1) done_cnt[d]++;
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame model: start 0, data LSB first, optional parity, stop bits of 1.
  task automatic model_bits(input int d, input logic [7:0] data,
                            input logic pen, input logic podd);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(data[i]);
    if (pen) begin
      ones = $countones(data);
      // Odd parity makes the total count of ones odd, even makes it even.
      exp_q.push_back(podd ? ((ones % 2) == 0) : ((ones % 2) == 1));
    end
    for (int s = 0; s < ((d == 0) ? 1 : 2); s++) exp_q.push_back(1'b1);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: request a frame on the next rising edge.
  task automatic kick(input int d, input logic [7:0] data,
                      input logic pen, input logic podd);
    data_v     = data;
    pen_v      = pen;
    podd_v     = podd;
    start_v[d] = 1'b1;
  endtask

  // Follows a kicked frame cycle by cycle. Inputs are scrambled every cycle
  // to show the latched values are used. intrude >= 0 pulses tx_start in the
  // middle of that frame bit. chain issues the next request in the tx_done
  // cycle instead of returning to idle.
  task automatic check_frame(input int d, input logic [7:0] data,
                             input logic pen, input logic podd,
                             input int intrude, input bit chain,
                             input logic [7:0] cdata, input logic cpen,
                             input logic cpodd);
    int nbits;
    int base;
    int errs;
    model_bits(d, data, pen, podd);
    nbits = exp_q.size();
    base  = 0;
    for (int b = 0; b < nbits; b++) begin
      errs = 0;
      for (int c = 0; c < BIT_CYC; c++) begin
        @(negedge sys_clk);
        if (b == 0 && c == 0) begin
          start_v[d] = 1'b0;
          base = done_cnt[d];
        end
        data_v = 8'($urandom);
        pen_v  = 1'($urandom);
        podd_v = 1'($urandom);
        if (b == intrude) start_v[d] = (c == 100);
        if (tx_w[d] !== exp_q[b] || en_w[d] !== 1'b1 ||
            busy_w[d] !== 1'b1 || done_w[d] !== 1'b0) errs++;
      end
      chk($sformatf("d%0d_%02h_bit%0d_bad_cycles", d, data, b), 32'(errs), 32'd0);
    end
    start_v[d] = 1'b0;
    @(negedge sys_clk);
    chk($sformatf("d%0d_%02h_done", d, data), 32'(done_w[d]), 32'd1);
    chk($sformatf("d%0d_%02h_idle_busy", d, data), 32'(busy_w[d]), 32'd0);
    chk($sformatf("d%0d_%02h_idle_en", d, data), 32'(en_w[d]), 32'd0);
    chk($sformatf("d%0d_%02h_idle_tx", d, data), 32'(tx_w[d]), 32'd1);
    if (chain) begin
      kick(d, cdata, cpen, cpodd);
    end else begin
      @(negedge sys_clk);
      chk($sformatf("d%0d_%02h_done_width", d, data), 32'(done_w[d]), 32'd0);
      chk($sformatf("d%0d_%02h_done_count", d, data), 32'(done_cnt[d] - base), 32'd1);
    end
  endtask

  // Confirms an instance sits idle for n cycles.
  task automatic check_idle(input int d, input int n, input string tag);
    int errs;
    errs = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge sys_clk);
      if (tx_w[d] !== 1'b1 || busy_w[d] !== 1'b0 || en_w[d] !== 1'b0) errs++;
    end
    chk(tag, 32'(errs), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int base;
    int errs;
    logic [7:0] rd;
    logic       rp, ro;
    logic [7:0] rd2;

    data_v  = 8'h00;
    pen_v   = 1'b0;
    podd_v  = 1'b0;
    start_v = 2'b00;

    repeat (3) @(negedge sys_clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_tx%0d", d), 32'(tx_w[d]), 32'd1);
      chk($sformatf("reset_en%0d", d), 32'(en_w[d]), 32'd0);
      chk($sformatf("reset_busy%0d", d), 32'(busy_w[d]), 32'd0);
      chk($sformatf("reset_done%0d", d), 32'(done_w[d]), 32'd0);
    end
    chk("reset_state0", 32'(dbg0), 32'(ST_IDLE));
    reset_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // A5, no parity, one stop bit.
    kick(0, 8'hA5, 1'b0, 1'b0);
    check_frame(0, 8'hA5, 1'b0, 1'b0, -1, 1'b0, 8'h00, 1'b0, 1'b0);

    // A5 with even and odd parity.
    kick(0, 8'hA5, 1'b1, 1'b0);
    check_frame(0, 8'hA5, 1'b1, 1'b0, -1, 1'b0, 8'h00, 1'b0, 1'b0);
    kick(0, 8'hA5, 1'b1, 1'b1);
    check_frame(0, 8'hA5, 1'b1, 1'b1, -1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Two stop bits, all-zero data.
    kick(1, 8'h00, 1'b0, 1'b0);
    check_frame(1, 8'h00, 1'b0, 1'b0, -1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Request during data bit 3 (frame bit 4) is dropped.
    base = done_cnt[0];
    kick(0, 8'h3C, 1'b0, 1'b0);
    check_frame(0, 8'h3C, 1'b0, 1'b0, 4, 1'b0, 8'h00, 1'b0, 1'b0);
    check_idle(0, 600, "intrude_no_second_frame");
    chk("intrude_done_count", 32'(done_cnt[0] - base), 32'd1);

    // Reset during data bit 5 (frame bit 6).
    base = done_cnt[0];
    kick(0, 8'hC3, 1'b1, 1'b1);
    model_bits(0, 8'hC3, 1'b1, 1'b1);
    errs = 0;
    for (int c = 0; c < 6 * BIT_CYC + 60; c++) begin
      @(negedge sys_clk);
      if (c == 0) start_v[0] = 1'b0;
      if (tx_w[0] !== exp_q[c / BIT_CYC]) errs++;
    end
    chk("abort_prefix_bad_cycles", 32'(errs), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_tx", 32'(tx_w[0]), 32'd1);
    chk("abort_en", 32'(en_w[0]), 32'd0);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_done", 32'(done_w[0]), 32'd0);
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    check_idle(0, 300, "abort_idle");
    chk("abort_no_done", 32'(done_cnt[0] - base), 32'd0);
    kick(0, 8'h81, 1'b0, 1'b0);
    check_frame(0, 8'h81, 1'b0, 1'b0, -1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Back-to-back: second request in the tx_done cycle.
    rd  = 8'($urandom);
    rd2 = 8'($urandom);
    rp  = 1'($urandom);
    ro  = 1'($urandom);
    kick(0, rd, rp, ro);
    check_frame(0, rd, rp, ro, -1, 1'b1, rd2, ro, rp);
    check_frame(0, rd2, ro, rp, -1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Random frames on both instances.
    for (int k = 0; k < 6; k++) begin
      int d;
      d  = (k < 4) ? 0 : 1;
      rd = 8'($urandom);
      rp = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 20)) @(negedge sys_clk);
      kick(d, rd, rp, ro);
      check_frame(d, rd, rp, ro, -1, 1'b0, 8'h00, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
